acc_matmul_core: RTL
====================

ACC_MATMUL_CORE -- requirements
Module: acc_matmul_core

Interface
REQ-001 The block SHALL have one clock and one reset: clk, rising-edge; rst_n, synchronous, active-low.
REQ-002 Parameter: DIM, 32, matrix dimension; power of two, range 2..32.
REQ-003 Parameter: AW, 2*log2(DIM), element address width (10 at DIM=32).
REQ-004 Port clk  in  1  system clock.
REQ-005 Port rst_n  in  1  synchronous active-low reset.
REQ-006 Port start  in  1  level; sampled only in IDLE.
REQ-007 Port busy  out  1  high while a multiply is in progress.
REQ-008 Port done  out  1  one-cycle completion pulse.
REQ-009 Port a_addr  out  AW  read address into the A byte store, row-major, A[i][k] at i*DIM+k.
REQ-010 Port a_rdata  in  8  unsigned A byte; valid exactly one cycle after a_addr.
REQ-011 Port b_addr  out  AW  read address into the B byte store, row-major, B[k][j] at k*DIM+j.
REQ-012 Port b_rdata  in  8  unsigned B byte; valid exactly one cycle after b_addr.
REQ-013 Port c_we  out  1  write strobe into the C byte store.
REQ-014 Port c_addr  out  AW  C write address, C[i][j] at i*DIM+j.
REQ-015 Port c_wdata  out  8  C result byte.

Function
REQ-016 The block SHALL compute C = A x B over unsigned 8-bit elements.
REQ-017 The FSM SHALL have states IDLE, RUN, DRAIN, WRITE, FIN.
REQ-018 IDLE: start=1 at a rising edge -> RUN; clear i, j, k and the accumulator.
REQ-019 RUN: each cycle, drive a_addr=i*DIM+k and b_addr=k*DIM+j, then increment k; after issuing k=DIM-1, go to DRAIN.
REQ-020 Each cycle, the accumulator SHALL add a_rdata*b_rdata for the address pair issued in the previous cycle.
REQ-021 The accumulator SHALL be 16+log2(DIM) bits wide and SHALL NOT overflow.
REQ-022 DRAIN: one cycle; the accumulator SHALL add the final (k=DIM-1) product.
REQ-023 WRITE: one cycle with c_we=1, c_addr=i*DIM+j, and c_wdata=min(acc,255), saturating.
REQ-024 After WRITE, the accumulator and k SHALL be cleared and j incremented; when j wraps, i SHALL be incremented.
REQ-025 After WRITE of element (DIM-1, DIM-1), the FSM SHALL go to FIN; otherwise it SHALL return to RUN.
REQ-026 FIN: done=1 for exactly one cycle, then IDLE.
REQ-027 busy SHALL be 1 in RUN, DRAIN, WRITE and FIN, and 0 in IDLE.
REQ-028 Each element SHALL take DIM+2 cycles.
REQ-029 done SHALL assert DIM*DIM*(DIM+2)+1 cycles after the edge that sampled start: 34817 at DIM=32, 97 at DIM=4.
REQ-030 start while busy=1 SHALL be ignored; a start held high after FIN SHALL begin a new run on the next IDLE edge.
REQ-031 C elements SHALL be written in ascending c_addr order, each exactly once per run.
REQ-032 c_we SHALL be 0 in every state except WRITE.
REQ-033 a_addr and b_addr SHALL hold 0 when not in RUN.
REQ-034 A/B store contents changing mid-run SHALL be consumed as read, with no protection or consistency check.

Reset
REQ-035 rst_n=0 at a rising edge SHALL force IDLE and clear i, j, k and the accumulator.
REQ-036 During reset, busy, done and c_we SHALL be 0, and c_addr, c_wdata, a_addr and b_addr SHALL be 0.
REQ-037 Reset mid-run SHALL abort the run: no further C writes, no done pulse; C bytes already written stay as written.
REQ-038 Reset SHALL take priority over start in the same cycle.

Verification (DIM=4, single-cycle-latency memory models)
REQ-039 A=identity, B[n]=n+1, start 1 cycle -> 16 writes with C[n]=n+1, and done exactly 97 cycles after start.
REQ-040 A=all 255, B=all 255 -> every C byte=255 (saturated, since acc=260100); A=all 1, B=all 3 -> every C byte=12.
REQ-041 A=all 0, arbitrary B -> 16 writes of 0, addresses 0..15 in order, c_we high for exactly 16 cycles.
REQ-042 start pulsed again at cycle 40 of a run -> no restart; done at cycle 97; exactly 16 writes.
REQ-043 rst_n low for 1 cycle at cycle 50 -> busy=0 the next cycle, no further c_we, no done; a following start completes a full correct run.
REQ-044 start held high continuously -> back-to-back runs, done pulses spaced 98 cycles apart.

Source files
------------

// File: rtl/acc_matmul_core.sv
// -----------------------------------------------------------------------------
// acc_matmul_core
//
// Purpose:
//   Sequential unsigned 8-bit matrix multiplier, C = A x B, for DIM x DIM
//   matrices held in external byte stores. One multiply-accumulate is issued
//   per clock. Each C element takes DIM+2 cycles: DIM RUN cycles issuing the
//   A/B reads, one DRAIN cycle to fold in the last product, and one WRITE
//   cycle that stores the result, saturated to 255.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst_n    in   1   synchronous active-low reset
//   start    in   1   level; sampled only in IDLE
//   busy     out  1   high in RUN, DRAIN, WRITE and FIN
//   done     out  1   one-cycle completion pulse (FIN state)
//   a_addr   out  AW  A read address, A[i][k] at i*DIM+k (0 outside RUN)
//   a_rdata  in   8   A byte, valid one cycle after a_addr
//   b_addr   out  AW  B read address, B[k][j] at k*DIM+j (0 outside RUN)
//   b_rdata  in   8   B byte, valid one cycle after b_addr
//   c_we     out  1   C write strobe (WRITE state only)
//   c_addr   out  AW  C write address, C[i][j] at i*DIM+j
//   c_wdata  out  8   saturated C byte
// -----------------------------------------------------------------------------
module acc_matmul_core #(
    parameter int DIM = 32,
    parameter int AW  = 2 * $clog2(DIM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] a_addr,
    input  logic [7:0]    a_rdata,
    output logic [AW-1:0] b_addr,
    input  logic [7:0]    b_rdata,
    output logic          c_we,
    output logic [AW-1:0] c_addr,
    output logic [7:0]    c_wdata
);

    localparam int LW   = $clog2(DIM);
    // DIM products of at most 255*255 each: 16 bits plus log2(DIM) headroom.
    localparam int ACCW = 16 + LW;
    localparam logic [LW-1:0] LAST = LW'(DIM - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [LW-1:0]   i_q;
    logic [LW-1:0]   j_q;
    logic [LW-1:0]   k_q;
    logic [ACCW-1:0] acc;
    // High when the read data arriving this cycle belongs to an address pair
    // issued in the previous cycle (i.e. the previous state was RUN).
    logic            prod_vld;
    logic [15:0]     prod;
    logic [7:0]      acc_sat;

    assign prod    = 16'(a_rdata) * 16'(b_rdata);
    assign acc_sat = (acc > ACCW'(255)) ? 8'hFF : acc[7:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (k_q == LAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = WRITE;
            WRITE:   state_nxt = (i_q == LAST && j_q == LAST) ? FIN : RUN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Index counters and accumulator
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            acc      <= '0;
            prod_vld <= 1'b0;
        end else begin
            prod_vld <= (state == RUN);
            case (state)
                IDLE: begin
                    if (start) begin
                        i_q <= '0;
                        j_q <= '0;
                        k_q <= '0;
                        acc <= '0;
                    end
                end
                RUN: begin
                    // k wraps back to 0 after the last issue, ready for the
                    // next element.
                    k_q <= k_q + LW'(1);
                    if (prod_vld) acc <= acc + ACCW'(prod);
                end
                DRAIN: begin
                    // Last product (k = DIM-1) lands here.
                    acc <= acc + ACCW'(prod);
                end
                WRITE: begin
                    acc <= '0;
                    k_q <= '0;
                    j_q <= j_q + LW'(1);
                    if (j_q == LAST) i_q <= i_q + LW'(1);
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Gated by rst_n so every output reads 0 while reset is held,
    // even before the reset edge has moved the FSM to IDLE. With DIM a
    // power of two, i*DIM+k is just the concatenation {i, k}.
    // ------------------------------------------------------------------
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        c_we    = 1'b0;
        a_addr  = '0;
        b_addr  = '0;
        c_addr  = '0;
        c_wdata = '0;
        if (rst_n) begin
            busy = (state != IDLE);
            done = (state == FIN);
            if (state == RUN) begin
                a_addr = {i_q, k_q};
                b_addr = {k_q, j_q};
            end
            if (state == WRITE) begin
                c_we    = 1'b1;
                c_addr  = {i_q, j_q};
                c_wdata = acc_sat;
            end
        end
    end

endmodule
